countdown_timer: RTL

BCD countdown timer: the count-down counterpart of the stopwatch cascade. It loads a three-digit decimal preset (000–999) and decrements it once per DVSR clock cycles while i_go is high. At 000 it stops and flags completion. It sits beside the stopwatch in the timer/display path, with the same o_s2/o_s1/o_s0 digit outputs feeding the seven-segment multiplexer.

---
 rtl/countdown_pkg.sv | 48 ++++
 rtl/tick_gen.sv | 31 +++
 rtl/countdown_timer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and BCD helpers for the countdown timer
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Three decremented digits plus a flag telling whether the result is 000
  typedef struct packed {
    bcd_t s2;
    bcd_t s1;
    bcd_t s0;
    logic zero;
  } bcd3_dec_t;

  // Decrement a three-digit BCD value with borrow ripple; 000 wraps to 999
  function automatic bcd3_dec_t bcd_dec3(input bcd_t d2, input bcd_t d1, input bcd_t d0);
    bcd3_dec_t r;
    r.s2 = d2;
    r.s1 = d1;
    r.s0 = d0;
    if (d0 != 4'd0) begin
      r.s0 = d0 - 4'd1;
    end else begin
      r.s0 = BCD_MAX;
      if (d1 != 4'd0) begin
        r.s1 = d1 - 4'd1;
      end else begin
        r.s1 = BCD_MAX;
        r.s2 = (d2 != 4'd0) ? (d2 - 4'd1) : BCD_MAX;
      end
    end
    r.zero = (r.s2 == 4'd0) && (r.s1 == 4'd0) && (r.s0 == 4'd0);
    return r;
  endfunction

  // Out-of-range preset digits saturate at 9 so the digits never leave 0-9
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - count-step prescaler, one tick every DVSR enabled cycles
module tick_gen #(
  parameter int DVSR = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q;

  // The tick is the enabled edge on which the counter sits at its last value
  assign o_tick = i_en && (cnt_q == LAST);

  // Counter advances only while enabled and holds otherwise, so a pause keeps the partial period
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : (cnt_q + 1'b1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - BCD 000-999 countdown timer; COUNTDOWN_AUTO_RELOAD_EN enables periodic reload
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int DVSR = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d0,
  input  logic       i_go,
  output logic [3:0] o_s2,
  output logic [3:0] o_s1,
  output logic [3:0] o_s0,
  output logic       o_zero,
  output logic       o_done,
  output logic       o_running
);

  state_t    state_q, state_d;
  bcd_t      s2_q, s1_q, s0_q;
  bcd_t      s2_d, s1_d, s0_d;
  logic      done_d;
  logic      tick;
  bcd3_dec_t dec;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [11:0] shadow_q, shadow_d;
`endif

  // Load and clear both restart the step period from zero
  tick_gen #(.DVSR(DVSR)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_clr || i_load),
    .i_en   ((state_q == RUN) && i_go),
    .o_tick (tick)
  );

  assign dec       = bcd_dec3(s2_q, s1_q, s0_q);
  assign o_s2      = s2_q;
  assign o_s1      = s1_q;
  assign o_s0      = s0_q;
  assign o_zero    = (s2_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd0);
  assign o_running = (state_q == RUN);

  // Next state and digits: clear beats load beats go/tick handling
  always_comb begin
    state_d = state_q;
    s2_d    = s2_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    shadow_d = shadow_q;
`endif
    if (i_clr) begin
      state_d = IDLE;
      s2_d    = 4'd0;
      s1_d    = 4'd0;
      s0_d    = 4'd0;
    end else if (i_load) begin
      state_d = IDLE;
      s2_d    = bcd_clamp(i_d2);
      s1_d    = bcd_clamp(i_d1);
      s0_d    = bcd_clamp(i_d0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      shadow_d = {bcd_clamp(i_d2), bcd_clamp(i_d1), bcd_clamp(i_d0)};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // A zero count never starts, so go is ignored at 000
          if (i_go && !o_zero) state_d = RUN;
        end
        RUN: begin
          if (!i_go) begin
            state_d = IDLE;
          end else if (tick) begin
            s2_d = dec.s2;
            s1_d = dec.s1;
            s0_d = dec.s0;
            if (dec.zero) begin
              done_d  = 1'b1;
              state_d = DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (shadow_q != 12'd0) begin
                {s2_d, s1_d, s0_d} = shadow_q;
                state_d            = RUN;
              end
`endif
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, digit and done-pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      s2_q    <= 4'd0;
      s1_q    <= 4'd0;
      s0_q    <= 4'd0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      s2_q    <= s2_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      o_done  <= done_d;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Shadow copy of the last loaded preset for periodic reload
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_q <= 12'd0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

endmodule
